pug_rvcpack: RTL and testbench

PUG_RVCPACK -- requirements
Module: pug_rvcpack

---
 rtl/pug_rvcpack.sv | 212 +++++++++++++++++++++
 tb/tb_pug_rvcpack.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pug_rvcpack.sv
// pug_rvcpack: RV32I -> RVC compressor and halfword packer.
// Each accepted instruction is compressed to 16 bits when a rule matches,
// otherwise passed through as 32 bits; halfwords are packed little-endian
// into 32-bit code words. A stream end (in_last) flushes any pending
// halfword, padded with c.nop in the upper half.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_insn is the RV32I instruction,
//                       in_last marks the final instruction of a stream
//   out_valid/out_ready output handshake; out_word is the packed word,
//                       out_last marks the final word of a stream
//   cnt_c               saturating count of compressed instructions
module pug_rvcpack #(
    parameter int unsigned EN_C = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic [15:0] cnt_c
);

    localparam int unsigned IW = 32;
    localparam int unsigned HW = 16;
    localparam logic [HW-1:0] C_NOP   = 16'h0001;
    localparam logic [HW-1:0] CNT_MAX = 16'hFFFF;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;

    assign opcode = in_insn[6:0];
    assign rd     = in_insn[11:7];
    assign funct3 = in_insn[14:12];
    assign rs1    = in_insn[19:15];
    assign rs2    = in_insn[24:20];
    assign funct7 = in_insn[31:25];
    assign imm_i  = in_insn[31:20];
    assign imm_s  = {in_insn[31:25], in_insn[11:7]};

    // Instruction class and operand qualifiers
    logic is_addi, is_slli, is_add, is_lw, is_sw;
    logic imm_small, lw_off_ok, sw_off_ok;
    logic rd_p, rs1_p, rs2_p;

    assign is_addi   = (opcode == OP_IMM)   && (funct3 == 3'b000);
    assign is_slli   = (opcode == OP_IMM)   && (funct3 == 3'b001);
    assign is_add    = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'd0);
    assign is_lw     = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    assign is_sw     = (opcode == OP_STORE) && (funct3 == 3'b010);
    // imm fits a 6-bit signed field when bits 11:5 are a pure sign extension
    assign imm_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
    // word-aligned, non-negative offset below 128
    assign lw_off_ok = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
    assign sw_off_ok = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
    // register lies in x8..x15
    assign rd_p      = (rd[4:3]  == 2'b01);
    assign rs1_p     = (rs1[4:3] == 2'b01);
    assign rs2_p     = (rs2[4:3] == 2'b01);

    // Compression rules, first match wins
    logic [HW-1:0] c16_c;
    logic          comp_c;

    always_comb begin
        c16_c  = '0;
        comp_c = 1'b0;
        if (EN_C != 0) begin
            if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm_small) begin
                c16_c  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
                comp_c = 1'b1;
            end else if (is_addi && (rs1 == rd) && (rd != 5'd0) && (imm_i != 12'd0) && imm_small) begin
                c16_c  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
                comp_c = 1'b1;
            end else if (is_slli && (rs1 == rd) && (rd != 5'd0) && (funct7 == 7'd0) && (rs2 != 5'd0)) begin
                c16_c  = {3'b000, 1'b0, rd, rs2, 2'b10};
                comp_c = 1'b1;
            end else if (is_add && (rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                c16_c  = {3'b100, 1'b0, rd, rs2, 2'b10};
                comp_c = 1'b1;
            end else if (is_add && (rs1 == rd) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                c16_c  = {3'b100, 1'b1, rd, rs2, 2'b10};
                comp_c = 1'b1;
            end else if (is_lw && rd_p && rs1_p && lw_off_ok) begin
                c16_c  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
                comp_c = 1'b1;
            end else if (is_sw && rs1_p && rs2_p && sw_off_ok) begin
                c16_c  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
                comp_c = 1'b1;
            end
        end
    end

    // State
    logic [HW-1:0] pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          flush_q, flush_d;
    logic [IW-1:0] out_word_q, out_word_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [HW-1:0] cnt_q, cnt_d;

    logic out_free;
    logic accept;

    // Output register may be (re)loaded when empty or drained this cycle
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = out_free && !flush_q;
    assign accept   = in_valid && in_ready;

    // Packing next-state
    always_comb begin
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        flush_d     = flush_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        cnt_d       = cnt_q;

        if (flush_q) begin
            if (out_free) begin
                out_word_d  = {C_NOP, pend_q};
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                pend_v_d    = 1'b0;
                flush_d     = 1'b0;
            end
        end else if (accept) begin
            if (comp_c && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 16'd1;
            end
            case ({pend_v_q, comp_c})
                2'b01: begin
                    if (in_last) begin
                        out_word_d  = {C_NOP, c16_c};
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                    end else begin
                        pend_d   = c16_c;
                        pend_v_d = 1'b1;
                    end
                end
                2'b00: begin
                    out_word_d  = in_insn;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                end
                2'b11: begin
                    out_word_d  = {c16_c, pend_q};
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                    pend_v_d    = 1'b0;
                end
                2'b10: begin
                    // upper half of the instruction becomes the new pending halfword
                    out_word_d  = {in_insn[15:0], pend_q};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    pend_d      = in_insn[31:16];
                    flush_d     = in_last;
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            flush_q     <= 1'b0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            flush_q     <= flush_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cnt_c     = cnt_q;

endmodule

// File: tb/tb_pug_rvcpack.sv
// Testbench for pug_rvcpack: directed scenarios plus a randomized stream
// checked against a halfword-queue reference model.
module tb_pug_rvcpack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_insn;
    logic        in_last;
    logic        out_ready;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_word;
    logic [15:0] cnt_c;
    logic        nc_in_ready, nc_out_valid, nc_out_last;
    logic [31:0] nc_out_word;
    logic [15:0] nc_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] hq[$];
    logic [32:0] expq[$];
    logic [32:0] gotq[$];
    logic [15:0] cnt_m;

    pug_rvcpack #(.EN_C(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
        .cnt_c(cnt_c)
    );

    pug_rvcpack #(.EN_C(0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
        .in_insn(in_insn), .in_last(in_last), .out_valid(nc_out_valid),
        .out_ready(out_ready), .out_word(nc_out_word), .out_last(nc_out_last),
        .cnt_c(nc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compressor: the rules evaluated on integer field values
    function automatic bit ref_c(input logic [31:0] i, output logic [15:0] c);
        int op, f3, f7, rd, rs1, rs2, simm, soff, ci;
        op   = int'(i[6:0]);
        f3   = int'(i[14:12]);
        f7   = int'(i[31:25]);
        rd   = int'(i[11:7]);
        rs1  = int'(i[19:15]);
        rs2  = int'(i[24:20]);
        simm = int'($signed(i[31:20]));
        soff = int'($signed({i[31:25], i[11:7]}));
        ci   = -1;
        if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && simm >= -32 && simm <= 31)
            ci = (2 << 13) | (((simm >> 5) & 1) << 12) | (rd << 7) | ((simm & 31) << 2) | 1;
        else if (op == 19 && f3 == 0 && rs1 == rd && rd != 0 && simm != 0 && simm >= -32 && simm <= 31)
            ci = (((simm >> 5) & 1) << 12) | (rd << 7) | ((simm & 31) << 2) | 1;
        else if (op == 19 && f3 == 1 && f7 == 0 && rs1 == rd && rd != 0 && rs2 != 0)
            ci = (rd << 7) | (rs2 << 2) | 2;
        else if (op == 51 && f3 == 0 && f7 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
            ci = (4 << 13) | (rd << 7) | (rs2 << 2) | 2;
        else if (op == 51 && f3 == 0 && f7 == 0 && rs1 == rd && rd != 0 && rs2 != 0)
            ci = (4 << 13) | (1 << 12) | (rd << 7) | (rs2 << 2) | 2;
        else if (op == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15
                 && simm >= 0 && simm <= 124 && simm % 4 == 0)
            ci = (2 << 13) | (((simm >> 3) & 7) << 10) | ((rs1 - 8) << 7)
               | (((simm >> 2) & 1) << 6) | (((simm >> 6) & 1) << 5) | ((rd - 8) << 2);
        else if (op == 35 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15
                 && soff >= 0 && soff <= 124 && soff % 4 == 0)
            ci = (6 << 13) | (((soff >> 3) & 7) << 10) | ((rs1 - 8) << 7)
               | (((soff >> 2) & 1) << 6) | (((soff >> 6) & 1) << 5) | ((rs2 - 8) << 2);
        c = (ci >= 0) ? 16'(ci) : 16'h0000;
        return ci >= 0;
    endfunction

    // Model: stream of halfwords, paired into words, padded with c.nop at stream end
    task automatic model_accept(input logic [31:0] insn, input logic last);
        logic [15:0] c, lo, hi;
        bit ok;
        ok = ref_c(insn, c);
        if (ok) begin
            hq.push_back(c);
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end else begin
            hq.push_back(insn[15:0]);
            hq.push_back(insn[31:16]);
        end
        if (last && (hq.size() % 2 == 1)) hq.push_back(16'h0001);
        while (hq.size() >= 2) begin
            lo = hq.pop_front();
            hi = hq.pop_front();
            expq.push_back({last && (hq.size() == 0), hi, lo});
        end
    endtask

    // Random instruction biased toward the compressible classes and their edges
    function automatic logic [31:0] gen_insn();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [6:0]  f7;
        rd  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
        f7  = ($urandom % 4 == 0) ? 7'h20 : 7'h00;
        imm = 12'($urandom_range(0, 80)) - 12'd40;
        case ($urandom_range(0, 7))
            0: return {imm, (($urandom % 2) == 0) ? 5'd0 : rs1, 3'b000, rd, 7'h13};
            1: return {imm, rd, 3'b000, rd, 7'h13};
            2: return {f7, rs2, rd, 3'b001, rd, 7'h13};
            3: return {f7, rs2, 5'd0, 3'b000, rd, 7'h33};
            4: return {f7, rs2, (($urandom % 4) == 0) ? rs1 : rd, 3'b000, rd, 7'h33};
            5: begin
                imm = 12'($urandom_range(0, 130));
                return {imm, 5'($urandom_range(6, 17)), 3'b010, 5'($urandom_range(6, 17)), 7'h03};
            end
            6: begin
                imm = 12'($urandom_range(0, 130));
                return {imm[11:5], 5'($urandom_range(6, 17)), 5'($urandom_range(6, 17)),
                        3'b010, imm[4:0], 7'h23};
            end
            default: return $urandom;
        endcase
    endfunction

    // One clock of stimulus; records handshakes that complete at the next rising edge
    task automatic cycle(input logic v, input logic [31:0] insn, input logic last, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_insn   = insn;
        in_last   = last;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) model_accept(insn, last);
        if (out_valid && out_ready) gotq.push_back({out_last, out_word});
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_insn   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hq.delete();
        expq.delete();
        gotq.delete();
        cnt_m = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        n_vec++; if (out_word !== 32'h0) begin n_err++; $display("FAIL rst_word got %h exp 0", out_word); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b exp 0", out_last); end
        n_vec++; if (cnt_c !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %h exp 0", cnt_c); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_last();
        do_reset();
        cycle(1'b1, 32'h00150513, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL one_valid got %b exp 1", out_valid); end
        n_vec++; if (out_word !== 32'h00010505) begin n_err++; $display("FAIL one_word got %h exp 00010505", out_word); end
        n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL one_last got %b exp 1", out_last); end
        n_vec++; if (cnt_c !== 16'd1) begin n_err++; $display("FAIL one_cnt got %0d exp 1", cnt_c); end
    endtask

    task automatic test_pair();
        do_reset();
        cycle(1'b1, 32'h00500513, 1'b0, 1'b1);
        cycle(1'b1, 32'hFFF00593, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pair_pend_valid got %b exp 0", out_valid); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pair_valid got %b exp 1", out_valid); end
        n_vec++; if (out_word !== 32'h55FD4515) begin n_err++; $display("FAIL pair_word got %h exp 55fd4515", out_word); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL pair_last got %b exp 0", out_last); end
        n_vec++; if (cnt_c !== 16'd2) begin n_err++; $display("FAIL pair_cnt got %0d exp 2", cnt_c); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pair_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1'b1, 32'h00500513, 1'b0, 1'b1);
        cycle(1'b1, 32'h123452B7, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h52B74515) begin n_err++; $display("FAIL flush_w0 got %h exp 52b74515", out_word); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL flush_l0 got %b exp 0", out_last); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_v1 got %b exp 1", out_valid); end
        n_vec++; if (out_word !== 32'h00011234) begin n_err++; $display("FAIL flush_w1 got %h exp 00011234", out_word); end
        n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL flush_l1 got %b exp 1", out_last); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after got %b exp 1", in_ready); end
    endtask

    task automatic test_passthru();
        do_reset();
        cycle(1'b1, 32'h00000013, 1'b0, 1'b1);
        cycle(1'b1, 32'h02050513, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h00000013) begin n_err++; $display("FAIL pass_nop got %h exp 00000013", out_word); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h02050513) begin n_err++; $display("FAIL pass_imm32 got %h exp 02050513", out_word); end
        n_vec++; if (cnt_c !== 16'd0) begin n_err++; $display("FAIL pass_cnt got %0d exp 0", cnt_c); end
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle(1'b1, 32'h00008067, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000013, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (out_word !== 32'h00008067) begin n_err++; $display("FAIL bp_hold_word got %h exp 00008067", out_word); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got %b exp 0", in_ready); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid got %b exp 1", out_valid); end
            cycle(1'b1, 32'h00000013, 1'b0, (k == 2) ? 1'b1 : 1'b0);
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume_ready got %b exp 1", in_ready); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h00000013) begin n_err++; $display("FAIL bp_next_word got %h exp 00000013", out_word); end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
        n_vec++; if (gotq.size() !== 2) begin n_err++; $display("FAIL bp_count got %0d exp 2", gotq.size()); end
        else if (gotq[0][31:0] !== 32'h00008067 || gotq[1][31:0] !== 32'h00000013) begin
            n_err++; $display("FAIL bp_order got %h %h exp 00008067 00000013", gotq[0][31:0], gotq[1][31:0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 32'h00500513, 1'b0, 1'b0);
        cycle(1'b1, 32'h123452B7, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        n_vec++; if (out_word !== 32'h0) begin n_err++; $display("FAIL mid_word got %h exp 0", out_word); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL mid_last got %b exp 0", out_last); end
        n_vec++; if (cnt_c !== 16'h0) begin n_err++; $display("FAIL mid_cnt got %h exp 0", cnt_c); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h00008067, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h00008067) begin n_err++; $display("FAIL mid_fresh got %h exp 00008067", out_word); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL mid_fresh_last got %b exp 0", out_last); end
        cycle(1'b1, 32'h00150513, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (out_word !== 32'h00010505) begin n_err++; $display("FAIL mid_no_stale got %h exp 00010505", out_word); end
    endtask

    task automatic test_no_compress();
        logic [31:0] x, px;
        logic        l, pl;
        do_reset();
        px = '0;
        pl = 1'b0;
        for (int k = 0; k < 12; k++) begin
            x = gen_insn();
            l = (k == 11);
            cycle(1'b1, x, l, 1'b1);
            n_vec++; if (nc_in_ready !== 1'b1) begin n_err++; $display("FAIL nc_ready got %b exp 1", nc_in_ready); end
            if (k > 0) begin
                n_vec++;
                if (nc_out_valid !== 1'b1 || nc_out_word !== px || nc_out_last !== pl) begin
                    n_err++;
                    $display("FAIL nc_word got %b %h %b exp 1 %h %b", nc_out_valid, nc_out_word, nc_out_last, px, pl);
                end
            end
            px = x;
            pl = l;
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (nc_out_word !== px || nc_out_last !== 1'b1) begin n_err++; $display("FAIL nc_final got %h %b exp %h 1", nc_out_word, nc_out_last, px); end
        n_vec++; if (nc_cnt !== 16'd0) begin n_err++; $display("FAIL nc_cnt got %0d exp 0", nc_cnt); end
    endtask

    task automatic test_random();
        localparam int N = 600;
        logic [31:0] cur, pw;
        logic        cur_last, v, r, stall, pv, pl;
        int          sent;
        do_reset();
        sent     = 0;
        cur      = gen_insn();
        cur_last = ($urandom % 8 == 0);
        stall    = 1'b0;
        pw = '0; pv = 1'b0; pl = 1'b0;
        for (int cyc = 0; cyc < 6000 && sent < N; cyc++) begin
            v = ($urandom % 4) != 0;
            r = ($urandom % 10) < 7;
            cycle(v, cur, cur_last, r);
            if (stall) begin
                n_vec++;
                if (out_valid !== pv || out_word !== pw || out_last !== pl) begin
                    n_err++;
                    $display("FAIL rnd_hold got %b %h %b exp %b %h %b", out_valid, out_word, out_last, pv, pw, pl);
                end
            end
            stall = out_valid && !out_ready;
            pv = out_valid; pw = out_word; pl = out_last;
            if (v && in_ready) begin
                sent++;
                cur      = gen_insn();
                cur_last = (sent == N - 1) || ($urandom % 8 == 0);
            end
        end
        n_vec++; if (sent != N) begin n_err++; $display("FAIL rnd_timeout got %0d accepted exp %0d", sent, N); end
        for (int k = 0; k < 20 && gotq.size() < expq.size(); k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (gotq.size() != expq.size()) begin n_err++; $display("FAIL rnd_words got %0d exp %0d", gotq.size(), expq.size()); end
        for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
            n_vec++;
            if (gotq[k] !== expq[k]) begin
                n_err++;
                $display("FAIL rnd_word[%0d] got last=%b %h exp last=%b %h", k, gotq[k][32], gotq[k][31:0], expq[k][32], expq[k][31:0]);
            end
        end
        n_vec++; if (cnt_c !== cnt_m) begin n_err++; $display("FAIL rnd_cnt got %0d exp %0d", cnt_c, cnt_m); end
    endtask

    initial begin
        test_reset();
        test_single_last();
        test_pair();
        test_flush();
        test_passthru();
        test_backpressure();
        test_reset_mid();
        test_no_compress();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
